fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Feeds the decode stage directly.
- Owns the PC and the boot sequence: it loads the PC from the reset vector word.
- Tags immediate words so decode forces them to NOP.
- Handles branch redirects, stalls, flushes and interrupt entry through the interrupt vector word.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
RESET_VEC_ADDR, 0, imem address holding the boot PC
IRQ_VEC_ADDR, 1, imem address holding the interrupt handler PC
IMM_MASK, 16'h0000, one-hot over opcode[15:12]; bit k=1 means opcode k is followed by one immediate word

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
imem_addr  out  ADDR_W  instruction-memory address (combinational read, data valid same cycle)
imem_data  in  16  instruction-memory read data
stall  in  1  hazard stall: hold PC and IF/ID
flush  in  1  replace IF/ID with bubble
branch_taken  in  1  redirect request from downstream
branch_target  in  ADDR_W  redirect PC
interrupt  in  1  interrupt request (level or pulse, sampled each cycle)
instruction  out  16  IF/ID instruction
pc_plus1  out  ADDR_W  IF/ID fetched PC + 1
imm_word  out  1  IF/ID word is an immediate operand, not an opcode
if_valid  out  1  IF/ID holds a real fetched word
irq_ack  out  1  one-cycle pulse when the handler PC is loaded
saved_pc  out  ADDR_W  return PC captured at interrupt entry

Behaviour:
- Reset (reset=0, async), applied immediately:
  - PC=0, state=BOOT, instruction=16'h0000, pc_plus1=0.
  - imm_word=0, if_valid=0, irq_ack=0, saved_pc=0, irq_pending=0, imm_expect=0.
- FSM states BOOT, RUN, VEC. All registers update on the rising clk edge.
- BOOT (one cycle after reset release):
  - imem_addr=RESET_VEC_ADDR; PC<=imem_data[ADDR_W-1:0]; IF/ID<=bubble; ->RUN.
  - stall and branch_taken are ignored in BOOT.
- Bubble means: instruction=0, if_valid=0, imm_word=0; pc_plus1 is held.
- RUN: imem_addr=PC. Priority per cycle, highest first:
  1. branch_taken: PC<=branch_target; IF/ID<=bubble; imm_expect<=0. Overrides stall and flush.
  2. flush (no branch): IF/ID<=bubble; imm_expect<=0; PC<=PC+1.
  3. stall: PC, IF/ID and imm_expect hold.
  4. interrupt entry: taken when irq_pending=1 and imm_expect=0 (never between an opcode and its immediate).
     - saved_pc<=PC; irq_pending<=0; IF/ID<=bubble; ->VEC. PC is not advanced.
  5. normal: IF/ID<=(imem_data, PC+1, imm_word=imm_expect, if_valid=1); PC<=PC+1.
     - imm_expect<=IMM_MASK[imem_data[15:12]] & ~imm_expect.
- irq_pending <= 1 whenever interrupt=1 is sampled, in any state. It is cleared only on entry, and entry wins over a same-cycle set. A request arriving during BOOT is taken in RUN.
- VEC (one cycle):
  - imem_addr=IRQ_VEC_ADDR; PC<=imem_data[ADDR_W-1:0]; IF/ID<=bubble; irq_ack=1 this cycle only; ->RUN.
  - branch_taken in VEC: saved_pc<=branch_target, and the vector load still happens.
  - stall in VEC is ignored.
- PC+1 wraps modulo 2^ADDR_W; pc_plus1 wraps identically.
- Outputs are registered, except imem_addr and irq_ack (combinational from state).
- Reset asserted mid-operation returns to BOOT regardless of state or pending interrupt.

Test Plan:
- Boot: imem[0]=0x0010, release reset -> cycle 1 imem_addr=0; cycle 2 imem_addr=0x0010 and if_valid=0; cycle 3 instruction=imem[0x10], pc_plus1=0x11, if_valid=1.
- Immediate tagging: IMM_MASK bit 3 set, imem[0x10]=0x3200, imem[0x11]=0x00FF -> 0x3200 appears with imm_word=0, then 0x00FF with imm_word=1; 0x3200 in the second word position is not re-tagged.
- Stall/branch: stall=1 for 3 cycles -> IF/ID and imem_addr frozen. branch_taken=1 with stall=1 and target 0x0040 -> next cycle bubble, then imem_addr=0x0040.
- Interrupt: imem[1]=0x0080, interrupt pulse while the word after an immediate-opcode is pending -> entry delayed one fetch. saved_pc=return PC, irq_ack pulses exactly once, next fetch address 0x0080.
- Wrap and reset: PC=0xFFFF fetch -> pc_plus1=0x0000 and next imem_addr=0x0000. Assert reset mid-VEC -> all outputs zero immediately and the FSM restarts in BOOT.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register. Loads the PC from the reset vector at boot, tags
// immediate words, and handles branch redirects, flushes, stalls and interrupt entry.
module fetch_stage #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned RESET_VEC_ADDR = 0,
    parameter int unsigned IRQ_VEC_ADDR   = 1,
    parameter logic [15:0] IMM_MASK       = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              interrupt,
    output logic [15:0]       instruction,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              imm_word,
    output logic              if_valid,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] saved_pc
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        VEC
    } state_e;

    typedef struct packed {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] pc_plus1;
        logic              imm;
        logic              valid;
    } ifid_t;

    localparam logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_ADDR);
    localparam logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(IRQ_VEC_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
    logic              irq_pending_q, irq_pending_d;
    logic              imm_expect_q, imm_expect_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] vector_pc;
    ifid_t             ifid_bubble;

    assign pc_inc      = pc_q + PC_ONE;
    assign vector_pc   = imem_data[ADDR_W-1:0];
    assign ifid_bubble = '{instr: 16'h0000, pc_plus1: ifid_q.pc_plus1, imm: 1'b0, valid: 1'b0};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_d        = ifid_q;
        saved_pc_d    = saved_pc_q;
        irq_pending_d = irq_pending_q | interrupt;
        imm_expect_d  = imm_expect_q;
        imem_addr     = pc_q;
        irq_ack       = 1'b0;

        unique case (state_q)
            BOOT: begin
                imem_addr = RESET_VEC;
                pc_d      = vector_pc;
                ifid_d    = ifid_bubble;
                state_d   = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_d         = branch_target;
                    ifid_d       = ifid_bubble;
                    imm_expect_d = 1'b0;
                end else if (flush) begin
                    pc_d         = pc_inc;
                    ifid_d       = ifid_bubble;
                    imm_expect_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (irq_pending_q && !imm_expect_q) begin
                    // Entry clears the request even if interrupt is still high this cycle.
                    saved_pc_d    = pc_q;
                    irq_pending_d = 1'b0;
                    ifid_d        = ifid_bubble;
                    state_d       = VEC;
                end else begin
                    ifid_d       = '{instr: imem_data, pc_plus1: pc_inc, imm: imm_expect_q, valid: 1'b1};
                    imm_expect_d = IMM_MASK[imem_data[15:12]] & ~imm_expect_q;
                    pc_d         = pc_inc;
                end
            end
            VEC: begin
                imem_addr = IRQ_VEC;
                irq_ack   = 1'b1;
                pc_d      = vector_pc;
                ifid_d    = ifid_bubble;
                state_d   = RUN;
                if (branch_taken) begin
                    saved_pc_d = branch_target;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= '0;
            ifid_q        <= '0;
            saved_pc_q    <= '0;
            irq_pending_q <= 1'b0;
            imm_expect_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_q        <= ifid_d;
            saved_pc_q    <= saved_pc_d;
            irq_pending_q <= irq_pending_d;
            imm_expect_q  <= imm_expect_d;
        end
    end

    assign instruction = ifid_q.instr;
    assign pc_plus1    = ifid_q.pc_plus1;
    assign imm_word    = ifid_q.imm;
    assign if_valid    = ifid_q.valid;
    assign saved_pc    = saved_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [15:0] IMM_MASK = 16'h0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall, flush, branch_taken, interrupt;
    logic [15:0] branch_target;
    logic [15:0] instruction, pc_plus1, saved_pc;
    logic        imm_word, if_valid, irq_ack;

    logic [15:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .ADDR_W        (16),
        .RESET_VEC_ADDR(0),
        .IRQ_VEC_ADDR  (1),
        .IMM_MASK      (IMM_MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .interrupt    (interrupt),
        .instruction  (instruction),
        .pc_plus1     (pc_plus1),
        .imm_word     (imm_word),
        .if_valid     (if_valid),
        .irq_ack      (irq_ack),
        .saved_pc     (saved_pc)
    );

    always #5 clk = ~clk;

    // Behavioural model: where the next fetch comes from, what IF/ID should hold,
    // whether the next word is an operand, and whether an interrupt is waiting.
    logic [15:0] m_pc, m_instr, m_pcp1, m_saved;
    bit          m_imm, m_valid, m_irq, m_next_is_operand, m_booting, m_vectoring;

    function automatic logic [15:0] m_addr();
        if (m_booting) return 16'h0000;
        if (m_vectoring) return 16'h0001;
        return m_pc;
    endfunction

    function automatic logic [49:0] m_regs();
        return {m_instr, m_pcp1, m_imm, m_valid, m_saved};
    endfunction

    function automatic logic [49:0] dut_regs();
        return {instruction, pc_plus1, imm_word, if_valid, saved_pc};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pcp1 = 0; m_saved = 0;
        m_imm = 0; m_valid = 0; m_irq = 0; m_next_is_operand = 0;
        m_booting = 1; m_vectoring = 0;
    endtask

    task automatic model_bubble();
        m_instr = 0; m_valid = 0; m_imm = 0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        bit          new_request;
        w = mem[m_addr()];
        new_request = interrupt;
        if (m_booting) begin
            m_pc = w; model_bubble(); m_booting = 0;
        end else if (m_vectoring) begin
            m_pc = w; model_bubble(); m_vectoring = 0;
            if (branch_taken) m_saved = branch_target;
        end else if (branch_taken) begin
            m_pc = branch_target; model_bubble(); m_next_is_operand = 0;
        end else if (flush) begin
            m_pc = m_pc + 16'd1; model_bubble(); m_next_is_operand = 0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_irq && !m_next_is_operand) begin
            m_saved = m_pc; model_bubble(); m_vectoring = 1;
            m_irq = 0; new_request = 0;
        end else begin
            m_instr = w; m_pcp1 = m_pc + 16'd1; m_imm = m_next_is_operand; m_valid = 1;
            m_next_is_operand = !m_next_is_operand && IMM_MASK[w[15:12]];
            m_pc = m_pc + 16'd1;
        end
        if (new_request) m_irq = 1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; branch_taken = 0; interrupt = 0; branch_target = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        apply_reset();
        checks++;
        if ({instruction, pc_plus1, imm_word, if_valid, irq_ack, saved_pc} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {instruction, pc_plus1, imm_word, if_valid, irq_ack, saved_pc});
        end
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_imem_addr: got %h expected 0000", imem_addr);
        end
    endtask

    task automatic test_boot();
        mem[16'h0000] = 16'h0010;
        mem[16'h0010] = 16'h1234;
        mem[16'h0011] = 16'h5555;
        clear_inputs();
        apply_reset();
        release_reset();
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++; $display("FAIL boot_cycle1_addr: got %h expected 0000", imem_addr);
        end
        tick();
        checks++;
        if (imem_addr !== 16'h0010 || if_valid !== 1'b0) begin
            errors++; $display("FAIL boot_cycle2: got addr %h valid %b expected 0010 0", imem_addr, if_valid);
        end
        tick();
        checks++;
        if (instruction !== 16'h1234 || pc_plus1 !== 16'h0011 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot_first_fetch: got %h %h %b expected 1234 0011 1", instruction, pc_plus1, if_valid);
        end
    endtask

    task automatic test_imm_tagging();
        logic [15:0] words [5] = '{16'h3200, 16'h00FF, 16'h3200, 16'h3200, 16'h1111};
        bit          tags  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        mem[16'h0000] = 16'h0010;
        for (int i = 0; i < 5; i++) mem[16'h0010 + 16'(i)] = words[i];
        clear_inputs();
        apply_reset();
        release_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instruction !== words[i] || imm_word !== tags[i] || if_valid !== 1'b1) begin
                errors++;
                $display("FAIL imm_tag[%0d]: got %h imm %b expected %h imm %b", i, instruction, imm_word, words[i], tags[i]);
            end
        end
    endtask

    task automatic test_stall_branch();
        logic [15:0] held_instr, held_addr;
        mem[16'h0000] = 16'h0010;
        for (int i = 0; i < 8; i++) mem[16'h0010 + 16'(i)] = 16'h1000 + 16'(i);
        for (int i = 0; i < 4; i++) mem[16'h0040 + 16'(i)] = 16'h2040 + 16'(i);
        clear_inputs();
        apply_reset();
        release_reset();
        tick(); tick(); tick();
        held_instr = 16'h1001;
        held_addr  = 16'h0012;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instruction !== held_instr || imem_addr !== held_addr) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h @%h expected %h @%h", i, instruction, imem_addr, held_instr, held_addr);
            end
        end
        branch_taken = 1; branch_target = 16'h0040;
        tick();
        branch_taken = 0; stall = 0;
        checks++;
        if (if_valid !== 1'b0 || instruction !== 16'h0000 || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL branch_over_stall: got valid %b instr %h addr %h expected 0 0000 0040", if_valid, instruction, imem_addr);
        end
        tick();
        checks++;
        if (instruction !== 16'h2040 || pc_plus1 !== 16'h0041) begin
            errors++; $display("FAIL branch_target_fetch: got %h %h expected 2040 0041", instruction, pc_plus1);
        end
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 16'h0042 || pc_plus1 !== 16'h0041) begin
            errors++;
            $display("FAIL flush_bubble: got valid %b addr %h pcp1 %h expected 0 0042 0041", if_valid, imem_addr, pc_plus1);
        end
    endtask

    task automatic test_interrupt();
        int acks = 0;
        mem[16'h0000] = 16'h0010;
        mem[16'h0001] = 16'h0080;
        mem[16'h0010] = 16'h3200;
        mem[16'h0011] = 16'h00AA;
        mem[16'h0012] = 16'h1000;
        mem[16'h0080] = 16'h2222;
        clear_inputs();
        apply_reset();
        release_reset();
        tick();
        interrupt = 1;
        tick();
        interrupt = 0;
        acks += int'(irq_ack);
        tick();
        acks += int'(irq_ack);
        checks++;
        if (instruction !== 16'h00AA || imm_word !== 1'b1 || imem_addr !== 16'h0012) begin
            errors++;
            $display("FAIL irq_deferred: got %h imm %b addr %h expected 00AA 1 0012", instruction, imm_word, imem_addr);
        end
        tick();
        acks += int'(irq_ack);
        checks++;
        if (irq_ack !== 1'b1 || imem_addr !== 16'h0001 || saved_pc !== 16'h0012 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL irq_vec: got ack %b addr %h saved %h valid %b expected 1 0001 0012 0", irq_ack, imem_addr, saved_pc, if_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            acks += int'(irq_ack);
        end
        checks++;
        if (instruction !== 16'h2222 || pc_plus1 !== 16'h0081) begin
            errors++; $display("FAIL irq_handler_fetch: got %h %h expected 2222 0081", instruction, pc_plus1);
        end
        checks++;
        if (acks !== 1) begin
            errors++; $display("FAIL irq_ack_count: got %0d expected 1", acks);
        end
    endtask

    task automatic test_wrap_reset();
        bit seen = 0;
        mem[16'h0000] = 16'hFFFF;
        mem[16'h0001] = 16'h0080;
        mem[16'hFFFF] = 16'h1234;
        clear_inputs();
        apply_reset();
        release_reset();
        tick();
        checks++;
        if (imem_addr !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_boot_addr: got %h expected ffff", imem_addr);
        end
        tick();
        checks++;
        if (instruction !== 16'h1234 || pc_plus1 !== 16'h0000 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_pc: got %h pcp1 %h addr %h expected 1234 0000 0000", instruction, pc_plus1, imem_addr);
        end
        interrupt = 1;
        tick();
        interrupt = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (irq_ack === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL wrap_irq_timeout: got no irq_ack expected one within 8 cycles");
        end
        apply_reset();
        checks++;
        if ({instruction, pc_plus1, imm_word, if_valid, irq_ack, saved_pc} !== 51'd0 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_vec: got %h addr %h expected 0 addr 0000",
                     {instruction, pc_plus1, imm_word, if_valid, irq_ack, saved_pc}, imem_addr);
        end
        release_reset();
        tick();
        checks++;
        if (imem_addr !== 16'hFFFF || if_valid !== 1'b0 || irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL reboot: got addr %h valid %b ack %b expected ffff 0 0", imem_addr, if_valid, irq_ack);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        clear_inputs();
        apply_reset();
        release_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(199) == 0) begin
                apply_reset();
                checks++;
                if (dut_regs() !== m_regs() || irq_ack !== 1'b0) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_reset @%0d: got %h expected %h", cyc, dut_regs(), m_regs());
                end
                release_reset();
                continue;
            end
            stall         = ($urandom_range(99) < 20);
            flush         = ($urandom_range(99) < 10);
            branch_taken  = ($urandom_range(99) < 10);
            interrupt     = ($urandom_range(99) < 6);
            branch_target = 16'($urandom);
            #1;
            checks++;
            if ({imem_addr, irq_ack} !== {m_addr(), m_vectoring}) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_comb @%0d: got %h/%b expected %h/%b", cyc, imem_addr, irq_ack, m_addr(), m_vectoring);
            end
            tick();
            checks++;
            if (dut_regs() !== m_regs()) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_regs @%0d: got %h expected %h", cyc, dut_regs(), m_regs());
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        clear_inputs();
        reset = 1;
        model_reset();
        #2;
        test_reset();
        test_boot();
        test_imm_tagging();
        test_stall_branch();
        test_interrupt();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
